bus_datapath_seq: RTL and testbench
===================================

// Module: bus_datapath_seq
// PURPOSE
//  Parametrised successor to the single-bus CPU datapath: register file, Y/Z/HI/LO staging registers and ALU on one internal bus.
//  Adds a built-in transfer sequencer that executes whole register-to-register ops from a valid/ready command port.
//  Sits between instruction decode/control and the register/ALU resources.
// PARAMETERS
//  DATA_W    32  datapath and bus width, in bits (>=8)
//  NUM_REGS  16  general registers; AW = $clog2(NUM_REGS)
//  R0_ZERO   1   1: R0 reads as 0 and ignores writes; 0: R0 is an ordinary register
// PORTS
//  Clock        in   1         single clock, rising edge
//  clr_n        in   1         asynchronous active-low reset
//  cmd_valid    in   1         command present
//  cmd_ready    out  1         sequencer idle, can accept
//  cmd_op       in   4         0 ADD,1 SUB,2 AND,3 OR,4 NOT,5 NEG,6 SHL,7 SHR,8 MOVE,9 MUL; others = NOP
//  cmd_ra       in   AW        destination register
//  cmd_rb       in   AW        source A (loaded into Y)
//  cmd_rc       in   AW        source B (unused when cmd_use_imm=1)
//  cmd_use_imm  in   1         source B = cmd_imm
//  cmd_imm      in   DATA_W    immediate operand
//  done_valid   out  1         one-cycle completion pulse
//  done_result  out  DATA_W    low word written back (Z low)
//  busy         out  1         = ~cmd_ready
//  ext_wr_en    in   1         external register load (preload/debug)
//  ext_wr_addr  in   AW        external load target
//  ext_wr_data  in   DATA_W    external load data
//  dbg_rd_addr  in   AW        debug read select
//  dbg_rd_data  out  DATA_W    combinational register read (R0 rule applies)
//  hi_q, lo_q   out  DATA_W    HI / LO register contents
//  bus_out      out  DATA_W    current internal bus value (observability)
//  flags        out  3         {N,Z,C}; see CONFIGURATION
// BEHAVIOUR
//  Reset (clr_n=0, async): all registers, Y, Z, HI, LO = 0; FSM=IDLE; cmd_ready=1; done_valid=0; done_result=0; flags=0.
//  Command latched (op, regs, imm captured) on rising edge with cmd_valid & cmd_ready; inputs ignored afterwards.
//  FSM: IDLE -> T_Y (Rb->bus, Yin) -> T_Z (Rc/imm->bus, ALU(Y,bus)->Z) -> T_WB (Zlo->bus, Ra written)
//       MUL only: T_WB writes LO (not Ra), then T_WB2 (Zhi->bus, HI written) -> IDLE.
//  done_valid high exactly one cycle, the cycle after last writeback, while FSM is IDLE; cmd_ready=1 that same cycle.
//  Latency accept-edge->done_valid: 4 cycles (non-MUL), 5 cycles (MUL); back-to-back throughput 1 cmd per 4/5 cycles.
//  Bus mux is one-hot by FSM state; IDLE bus_out = 0.
//  Arithmetic: ADD/SUB/NEG modulo 2^DATA_W; C = carry-out (ADD) / no-borrow (SUB); NOT, MOVE ignore Y / B respectively (MOVE: Ra=Rb).
//  SHL/SHR logical; amount = B[$clog2(DATA_W)-1:0].
//  MUL signed two's complement, 2*DATA_W product: Zhi=upper, Zlo=lower.
//  NOP opcodes: run full 4-cycle sequence, no register write, done_valid still pulses.
//  R0_ZERO=1: writes to R0 (seq or ext) discarded, reads of R0 give 0; done_result still reports computed value.
//  ext_wr and sequencer writeback to same register in same cycle: sequencer wins; different registers: both written.
//  ext_wr to Rb/Rc during T_Y/T_Z: operand sampled is value present on the bus that cycle (pre-write).
//  clr_n asserted mid-command: command abandoned, no partial write survives, no done_valid.
// CONFIGURATION
//  DP_FLAGS_EN defined: flags register updated on each T_WB (non-MUL, non-NOP) from Zlo: N=msb, Z=(Zlo==0), C per op (0 for logic/shift/MOVE).
//  DP_FLAGS_EN undefined: flag logic absent, flags tied to 3'b000.
// TESTING
//  Reset: clr_n=0 during MUL T_Z -> regs/HI/LO=0, cmd_ready=1, no done_valid after release.
//  ext_wr R1=5, R2=7; ADD ra=3 rb=1 rc=2 -> done_valid at accept+4, done_result=12, R3=12.
//  R1=-3 (0xFFFFFFFD), MUL rb=1 imm=0x10 -> done at accept+5, LO=0xFFFFFFD0, HI=0xFFFFFFFF.
//  R0_ZERO=1: ADD ra=0 rb=1(=5) imm=1 -> done_result=6, dbg_rd R0=0.
//  cmd_valid held with two cmds; 2nd accepted in 1st's done_valid cycle; ext_wr R3=0xAA in T_WB -> R3=seq value.
//  DP_FLAGS_EN: SUB ra=4 rb=1 rc=1 -> R4=0, flags={0,1,1}; without macro flags=0.

Source files
------------

// File: rtl/bus_datapath_seq.sv
// Single-bus datapath (regfile, Y/Z/HI/LO, ALU) with a valid/ready op sequencer.
// Optional macro DP_FLAGS_EN enables the {N,Z,C} flags register.
module bus_datapath_seq #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter bit R0_ZERO  = 1'b1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              Clock,
  input  logic              clr_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [AW-1:0]     cmd_ra,
  input  logic [AW-1:0]     cmd_rb,
  input  logic [AW-1:0]     cmd_rc,
  input  logic              cmd_use_imm,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              done_valid,
  output logic [DATA_W-1:0] done_result,
  output logic              busy,
  input  logic              ext_wr_en,
  input  logic [AW-1:0]     ext_wr_addr,
  input  logic [DATA_W-1:0] ext_wr_data,
  input  logic [AW-1:0]     dbg_rd_addr,
  output logic [DATA_W-1:0] dbg_rd_data,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q,
  output logic [DATA_W-1:0] bus_out,
  output logic [2:0]        flags
);

  localparam int SW = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_NEG  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_MOVE = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TY,
    S_TZ,
    S_TWB,
    S_TWB2
  } state_t;

  state_t r_state;
  state_t w_state_d;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_y;
  logic [DATA_W-1:0] r_zlo;
  logic [DATA_W-1:0] r_zhi;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_res;
  logic              r_done;

  logic [3:0]        r_op;
  logic [AW-1:0]     r_ra;
  logic [AW-1:0]     r_rb;
  logic [AW-1:0]     r_rc;
  logic              r_use_imm;
  logic [DATA_W-1:0] r_imm;

  logic [DATA_W-1:0] w_rb_val;
  logic [DATA_W-1:0] w_rc_val;
  logic [DATA_W-1:0] w_bus;
  logic [DATA_W-1:0] w_alu_lo;
  logic [DATA_W-1:0] w_alu_hi;
  logic              w_alu_c;
  logic [DATA_W:0]   w_add;
  logic [DATA_W:0]   w_sub;
  logic [2*DATA_W-1:0] w_prod;
  logic [SW-1:0]     w_amt;
  logic              w_is_mul;
  logic              w_is_nop;
  logic              w_accept;
  logic              w_ra_ok;
  logic              w_ext_ok;

  assign w_rb_val = (R0_ZERO && r_rb == '0) ? '0 : r_regs[r_rb];
  assign w_rc_val = (R0_ZERO && r_rc == '0) ? '0 : r_regs[r_rc];
  assign dbg_rd_data =
    (R0_ZERO && dbg_rd_addr == '0) ? '0 : r_regs[dbg_rd_addr];

  assign w_is_mul = (r_op == OP_MUL);
  assign w_is_nop = (r_op > OP_MUL);
  assign w_accept = cmd_valid & cmd_ready;
  assign w_ra_ok  = !(R0_ZERO && r_ra == '0);
  assign w_ext_ok = !(R0_ZERO && ext_wr_addr == '0);

  always_comb begin
    w_bus = '0;
    unique case (1'b1)
      (r_state == S_TY):   w_bus = w_rb_val;
      (r_state == S_TZ):   w_bus = r_use_imm ? r_imm : w_rc_val;
      (r_state == S_TWB):  w_bus = r_zlo;
      (r_state == S_TWB2): w_bus = r_zhi;
      default:             w_bus = '0;
    endcase
  end

  assign w_add = {1'b0, r_y} + {1'b0, w_bus};
  assign w_sub = {1'b0, r_y} + {1'b0, ~w_bus} + (DATA_W+1)'(1);
  assign w_amt = w_bus[SW-1:0];
  assign w_prod =
    $signed({{DATA_W{r_y[DATA_W-1]}}, r_y}) *
    $signed({{DATA_W{w_bus[DATA_W-1]}}, w_bus});

  always_comb begin
    w_alu_lo = '0;
    w_alu_hi = '0;
    w_alu_c  = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_alu_lo = w_add[DATA_W-1:0];
        w_alu_c  = w_add[DATA_W];
      end
      OP_SUB: begin
        w_alu_lo = w_sub[DATA_W-1:0];
        w_alu_c  = w_sub[DATA_W];
      end
      OP_AND:  w_alu_lo = r_y & w_bus;
      OP_OR:   w_alu_lo = r_y | w_bus;
      OP_NOT:  w_alu_lo = ~w_bus;
      OP_NEG: begin
        w_alu_lo = -w_bus;
        w_alu_c  = (w_bus == '0);
      end
      OP_SHL:  w_alu_lo = r_y << w_amt;
      OP_SHR:  w_alu_lo = r_y >> w_amt;
      OP_MOVE: w_alu_lo = r_y;
      OP_MUL: begin
        w_alu_lo = w_prod[DATA_W-1:0];
        w_alu_hi = w_prod[2*DATA_W-1:DATA_W];
      end
      default: w_alu_lo = '0;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    cmd_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_d = S_TY;
      end
      S_TY:    w_state_d = S_TZ;
      S_TZ:    w_state_d = S_TWB;
      S_TWB:   w_state_d = w_is_mul ? S_TWB2 : S_IDLE;
      S_TWB2:  w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge clr_n) begin
    if (!clr_n) r_state <= S_IDLE;
    else        r_state <= w_state_d;
  end

  always_ff @(posedge Clock or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_y       <= '0;
      r_zlo     <= '0;
      r_zhi     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_res     <= '0;
      r_done    <= 1'b0;
      r_op      <= '0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_rc      <= '0;
      r_use_imm <= 1'b0;
      r_imm     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_op      <= cmd_op;
        r_ra      <= cmd_ra;
        r_rb      <= cmd_rb;
        r_rc      <= cmd_rc;
        r_use_imm <= cmd_use_imm;
        r_imm     <= cmd_imm;
      end
      if (ext_wr_en && w_ext_ok)
        r_regs[ext_wr_addr] <= ext_wr_data;
      // sequencer writeback comes last so it wins a same-register clash
      case (r_state)
        S_TY: r_y <= w_bus;
        S_TZ: begin
          r_zlo <= w_alu_lo;
          r_zhi <= w_alu_hi;
        end
        S_TWB: begin
          if (w_is_mul) begin
            r_lo <= w_bus;
          end else begin
            r_done <= 1'b1;
            r_res  <= w_bus;
            if (!w_is_nop && w_ra_ok) r_regs[r_ra] <= w_bus;
          end
        end
        S_TWB2: begin
          r_hi   <= w_bus;
          r_done <= 1'b1;
          r_res  <= r_zlo;
        end
        default: ;
      endcase
    end
  end

`ifdef DP_FLAGS_EN
  logic       r_zc;
  logic [2:0] r_flags;

  always_ff @(posedge Clock or negedge clr_n) begin
    if (!clr_n) begin
      r_zc    <= 1'b0;
      r_flags <= 3'b000;
    end else begin
      if (r_state == S_TZ) r_zc <= w_alu_c;
      if (r_state == S_TWB && !w_is_mul && !w_is_nop)
        r_flags <= {w_bus[DATA_W-1], (w_bus == '0), r_zc};
    end
  end

  assign flags = r_flags;
`else
  logic w_unused_c;
  assign w_unused_c = w_alu_c;
  assign flags = 3'b000;
`endif

  assign done_valid  = r_done;
  assign done_result = r_res;
  assign hi_q        = r_hi;
  assign lo_q        = r_lo;
  assign bus_out     = w_bus;
  assign busy        = ~cmd_ready;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed bench for bus_datapath_seq: scoreboard of expected done_result
// values, immediate-assertion checks on latency, writeback, flags and reset.
module tb_bus_datapath_seq;

  logic        Clock = 1'b0;
  logic        clr_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [3:0]  cmd_ra = '0;
  logic [3:0]  cmd_rb = '0;
  logic [3:0]  cmd_rc = '0;
  logic        cmd_use_imm = 1'b0;
  logic [31:0] cmd_imm = '0;
  logic        done_valid;
  logic [31:0] done_result;
  logic        busy;
  logic        ext_wr_en = 1'b0;
  logic [3:0]  ext_wr_addr = '0;
  logic [31:0] ext_wr_data = '0;
  logic [3:0]  dbg_rd_addr = '0;
  logic [31:0] dbg_rd_data;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] bus_out;
  logic [2:0]  flags;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] sb[$];
  logic [31:0] b1, b2, b3, rd, e;
  logic [2:0]  exp_flags;
  int n;
  bit got;

  bus_datapath_seq #(.DATA_W(32), .NUM_REGS(16), .R0_ZERO(1'b1)) dut (
    .Clock(Clock), .clr_n(clr_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rc(cmd_rc),
    .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
    .done_valid(done_valid), .done_result(done_result), .busy(busy),
    .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr),
    .ext_wr_data(ext_wr_data),
    .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data),
    .hi_q(hi_q), .lo_q(lo_q), .bus_out(bus_out), .flags(flags)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rdreg(input logic [3:0] a, output logic [31:0] d);
    dbg_rd_addr = a;
    #1 d = dbg_rd_data;
  endtask

  task automatic ext(input logic [3:0] a, input logic [31:0] d);
    @(negedge Clock);
    ext_wr_en = 1'b1;
    ext_wr_addr = a;
    ext_wr_data = d;
    @(negedge Clock);
    ext_wr_en = 1'b0;
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [3:0] rc,
                       input logic ui, input logic [31:0] imm);
    cmd_op = op;
    cmd_ra = ra;
    cmd_rb = rb;
    cmd_rc = rc;
    cmd_use_imm = ui;
    cmd_imm = imm;
  endtask

  task automatic run_cmd(input string tag, input logic [3:0] op,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rc, input logic ui,
                         input logic [31:0] imm, input int exp_lat,
                         input logic [31:0] exp_res, input bit chk_res,
                         output logic [31:0] o1, output logic [31:0] o2,
                         output logic [31:0] o3);
    int k;
    bit seen;
    logic [31:0] ex;
    @(negedge Clock);
    check({tag, "_ready"}, cmd_ready, 1);
    drive(op, ra, rb, rc, ui, imm);
    cmd_valid = 1'b1;
    sb.push_back(exp_res);
    @(posedge Clock);
    #1 cmd_valid = 1'b0;
    o1 = bus_out;
    o2 = '0;
    o3 = '0;
    k = 0;
    seen = 0;
    while (!seen && k < 10) begin
      @(posedge Clock);
      #1 k++;
      if (k == 1) o2 = bus_out;
      if (k == 2) o3 = bus_out;
      if (done_valid) seen = 1;
    end
    check({tag, "_latency"}, k + 1, exp_lat);
    ex = sb.pop_front();
    if (seen) begin
      check({tag, "_ready_at_done"}, cmd_ready, 1);
      if (chk_res) check({tag, "_result"}, done_result, ex);
    end
    @(posedge Clock);
    #1 check({tag, "_pulse_end"}, done_valid, 0);
  endtask

  initial begin
    clr_n = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done_valid, 0);
    check("rst_result", done_result, 0);
    check("rst_flags", flags, 0);
    check("rst_hilo", {hi_q, lo_q}, 0);
    check("rst_bus", bus_out, 0);
    @(negedge Clock);
    clr_n = 1'b1;

    ext(4'd1, 32'd5);
    ext(4'd2, 32'd7);
    rdreg(4'd1, rd);
    check("ext_r1", rd, 5);

    run_cmd("add", 4'd0, 4'd3, 4'd1, 4'd2, 1'b0, 0, 4, 32'd12, 1,
            b1, b2, b3);
    check("add_bus_ty", b1, 5);
    check("add_bus_tz", b2, 7);
    check("add_bus_twb", b3, 12);
    rdreg(4'd3, rd);
    check("add_r3", rd, 12);

    ext(4'd1, 32'hFFFF_FFFD);
    run_cmd("mul", 4'd9, 4'd5, 4'd1, 4'd0, 1'b1, 32'h10, 5,
            32'hFFFF_FFD0, 1, b1, b2, b3);
    check("mul_lo", lo_q, 32'hFFFF_FFD0);
    check("mul_hi", hi_q, 32'hFFFF_FFFF);
    rdreg(4'd5, rd);
    check("mul_ra_untouched", rd, 0);

    ext(4'd1, 32'd5);
    run_cmd("r0add", 4'd0, 4'd0, 4'd1, 4'd0, 1'b1, 32'd1, 4, 32'd6, 1,
            b1, b2, b3);
    rdreg(4'd0, rd);
    check("r0_seq_write", rd, 0);
    ext(4'd0, 32'h55);
    rdreg(4'd0, rd);
    check("r0_ext_write", rd, 0);

    run_cmd("sub", 4'd1, 4'd4, 4'd1, 4'd1, 1'b0, 0, 4, 32'd0, 1,
            b1, b2, b3);
    rdreg(4'd4, rd);
    check("sub_r4", rd, 0);
`ifdef DP_FLAGS_EN
    exp_flags = 3'b011;
`else
    exp_flags = 3'b000;
`endif
    check("sub_flags", flags, exp_flags);

    ext(4'd8, 32'h81);
    run_cmd("shl", 4'd6, 4'd8, 4'd8, 4'd0, 1'b1, 32'd4, 4, 32'h810, 1,
            b1, b2, b3);
    run_cmd("shr", 4'd7, 4'd9, 4'd8, 4'd0, 1'b1, 32'd3, 4, 32'h102, 1,
            b1, b2, b3);
    run_cmd("not", 4'd4, 4'd10, 4'd1, 4'd2, 1'b0, 0, 4, 32'hFFFF_FFF8, 1,
            b1, b2, b3);
    run_cmd("move", 4'd8, 4'd11, 4'd2, 4'd1, 1'b0, 0, 4, 32'd7, 1,
            b1, b2, b3);
    rdreg(4'd11, rd);
    check("move_r11", rd, 7);
    run_cmd("nop", 4'd12, 4'd14, 4'd1, 4'd2, 1'b0, 0, 4, 32'd0, 0,
            b1, b2, b3);
    rdreg(4'd14, rd);
    check("nop_no_write", rd, 0);

    // back-to-back with ext write clash on R3
    @(negedge Clock);
    drive(4'd1, 4'd3, 4'd2, 4'd1, 1'b0, 0);
    cmd_valid = 1'b1;
    sb.push_back(32'd2);
    @(posedge Clock);
    #1;
    drive(4'd2, 4'd13, 4'd2, 4'd0, 1'b1, 32'd3);
    sb.push_back(32'd3);
    @(posedge Clock);
    #1 check("b2b_busy", busy, 1);
    @(posedge Clock);
    #1 check("b2b_twb_bus", bus_out, 2);
    @(negedge Clock);
    ext_wr_en = 1'b1;
    ext_wr_addr = 4'd3;
    ext_wr_data = 32'hAA;
    @(posedge Clock);
    #1 ext_wr_en = 1'b0;
    check("b2b_done1", done_valid, 1);
    check("b2b_ready1", cmd_ready, 1);
    e = sb.pop_front();
    check("b2b_result1", done_result, e);
    @(posedge Clock);
    #1 cmd_valid = 1'b0;
    check("b2b_accept2", busy, 1);
    n = 0;
    got = 0;
    while (!got && n < 10) begin
      @(posedge Clock);
      #1 n++;
      if (done_valid) got = 1;
    end
    check("b2b_latency2", n + 1, 4);
    e = sb.pop_front();
    check("b2b_result2", done_result, e);
    rdreg(4'd3, rd);
    check("b2b_seq_wins", rd, 2);
    rdreg(4'd13, rd);
    check("b2b_r13", rd, 3);

    // reset during MUL T_Z
    @(negedge Clock);
    drive(4'd9, 4'd5, 4'd1, 4'd0, 1'b1, 32'h10);
    cmd_valid = 1'b1;
    @(posedge Clock);
    #1 cmd_valid = 1'b0;
    @(posedge Clock);
    #1 check("midrst_in_tz", bus_out, 32'h10);
    @(negedge Clock);
    clr_n = 1'b0;
    #1;
    check("midrst_ready", cmd_ready, 1);
    check("midrst_hilo", {hi_q, lo_q}, 0);
    rdreg(4'd1, rd);
    check("midrst_r1", rd, 0);
    @(negedge Clock);
    clr_n = 1'b1;
    got = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clock);
      #1 if (done_valid) got = 1;
    end
    check("midrst_no_done", got, 0);
    check("midrst_hilo_after", {hi_q, lo_q}, 0);
    rdreg(4'd5, rd);
    check("midrst_r5", rd, 0);
    sb.delete();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
